// File: rtl/pc_fetch_ctrl.sv
// PC owner and instruction fetch sequencer.
// Fetches over imem req/ack, feeds decode, applies execute redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_inst,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc4,
  input  logic             id_stall,
  input  logic             ex_valid,
  input  logic             branch_signal,
  input  logic [31:0]      branch_target,
  output logic             fault,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    OUT,
    HALT
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               imem_req_q, imem_req_d;
  logic [31:0]        imem_addr_q, imem_addr_d;
  logic               if_valid_q, if_valid_d;
  logic [31:0]        if_inst_q, if_inst_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic [31:0]        if_pc4_q, if_pc4_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               discard_q, discard_d;
  logic [31:0]        pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;

  logic        redirect;
  logic [31:0] pc_inc;
  logic [31:0] drop_tgt;

  assign redirect = ex_valid & branch_signal;
  assign pc_inc   = pc_q + 32'd4;
  assign drop_tgt = redirect ? branch_target : pend_q;

  // Next-state, PC and output-register computation
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_inst_d    = if_inst_q;
    if_pc_d      = if_pc_q;
    if_pc4_d     = if_pc4_q;
    fault_d      = fault_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (redirect && state_q != HALT && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      BOOT: begin
        if (redirect && branch_target[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          if (redirect) pc_d = branch_target;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (discard_q || redirect) begin
            discard_d    = 1'b0;
            pend_valid_d = 1'b0;
            if (drop_tgt[1:0] != 2'b00) begin
              fault_d = 1'b1;
              state_d = HALT;
            end else begin
              pc_d = drop_tgt;
            end
          end else begin
            if_inst_d  = imem_rdata;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_inc;
            pc_d       = pc_inc;
            if_valid_d = 1'b1;
            state_d    = OUT;
          end
        end else if (redirect) begin
          // Address must stay put until the in-flight fetch returns
          discard_d    = 1'b1;
          pend_d       = branch_target;
          pend_valid_d = 1'b1;
        end
      end
      OUT: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          if (branch_target[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = branch_target;
            state_d = REQ;
          end
        end else if (!id_stall) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
      end
      default: state_d = HALT;
    endcase

    imem_req_d  = (state_d == REQ);
    imem_addr_d = pc_d;
  end

  // All architectural and output state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_inst_q    <= '0;
      if_pc_q      <= '0;
      if_pc4_q     <= '0;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      if_valid_q   <= if_valid_d;
      if_inst_q    <= if_inst_d;
      if_pc_q      <= if_pc_d;
      if_pc4_q     <= if_pc4_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign if_valid     = if_valid_q;
  assign if_inst      = if_inst_q;
  assign if_pc        = if_pc_q;
  assign if_pc4       = if_pc4_q;
  assign fault        = fault_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl.
// Reference model tracks the fetch stream from the behavioural rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          CW  = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic [31:0]   if_pc;
  logic [31:0]   if_pc4;
  logic          id_stall;
  logic          ex_valid;
  logic          branch_signal;
  logic [31:0]   branch_target;
  logic          fault;
  logic [CW-1:0] redirect_cnt;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4),
    .id_stall      (id_stall),
    .ex_valid      (ex_valid),
    .branch_signal (branch_signal),
    .branch_target (branch_target),
    .fault         (fault),
    .redirect_cnt  (redirect_cnt)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: where fetch is, what decode holds, what is stale
  bit          m_known, m_post_rst;
  bit          m_boot, m_req, m_have, m_halt, m_stale, m_fault;
  logic [31:0] m_pc, m_pend, m_inst, m_ipc;
  int          m_cnt;

  task automatic m_stop();
    m_halt  = 1;
    m_fault = 1;
    m_req   = 0;
    m_have  = 0;
  endtask

  task automatic m_step();
    bit          redir;
    logic [31:0] t;
    if (rst) begin
      m_known = 1; m_post_rst = 1;
      m_boot = 1; m_req = 0; m_have = 0; m_halt = 0;
      m_stale = 0; m_fault = 0; m_cnt = 0;
      m_pc = RPC; m_pend = 0; m_inst = 0; m_ipc = 0;
      return;
    end
    m_post_rst = 0;
    if (!m_known || m_halt) return;
    redir = ex_valid && branch_signal;
    if (redir && m_cnt < CMAX) m_cnt++;
    if (m_boot) begin
      m_boot = 0;
      if (redir && branch_target[1:0] != 0) m_stop();
      else begin
        if (redir) m_pc = branch_target;
        m_req = 1;
      end
    end else if (m_req) begin
      if (imem_ack) begin
        if (m_stale || redir) begin
          t = redir ? branch_target : m_pend;
          m_stale = 0;
          if (t[1:0] != 0) m_stop();
          else m_pc = t;
        end else begin
          m_have = 1; m_req = 0;
          m_inst = imem_rdata; m_ipc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end else if (redir) begin
        m_stale = 1;
        m_pend  = branch_target;
      end
    end else if (m_have) begin
      if (redir) begin
        m_have = 0;
        if (branch_target[1:0] != 0) m_stop();
        else begin
          m_pc = branch_target;
          m_req = 1;
        end
      end else if (!id_stall) begin
        m_have = 0;
        m_req  = 1;
      end
    end
  endtask

  task automatic m_check();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_have});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    chk("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    if (m_have) begin
      chk("if_inst", if_inst, m_inst);
      chk("if_pc", if_pc, m_ipc);
      chk("if_pc4", if_pc4, m_ipc + 32'd4);
    end
    if (m_post_rst) begin
      chk("rst_addr", imem_addr, RPC);
      chk("rst_inst", if_inst, 32'h0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_pc4", if_pc4, 32'h0);
    end
  endtask

  task automatic pick_target();
    int          r;
    logic [31:0] v;
    logic [1:0]  lo;
    r  = $urandom_range(0, 19);
    v  = $urandom;
    lo = 2'($urandom_range(1, 3));
    if (r == 0) branch_target = 32'hFFFF_FFFC;
    else if (r == 1) branch_target = {v[31:2], lo};
    else if (r < 6) branch_target = {24'h0, v[7:2], 2'b00};
    else branch_target = {v[31:2], 2'b00};
  endtask

  initial begin
    rst = 1; imem_ack = 0; imem_rdata = 0; id_stall = 0;
    ex_valid = 0; branch_signal = 0; branch_target = 0;
    m_known = 0; m_post_rst = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (m_known) m_check();
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0)
            || (m_halt && $urandom_range(0, 11) == 0);
      imem_ack      = m_req && ($urandom_range(0, 2) == 0);
      imem_rdata    = $urandom;
      id_stall      = ($urandom_range(0, 9) < 4);
      ex_valid      = ($urandom_range(0, 9) < 2);
      branch_signal = ($urandom_range(0, 1) == 1);
      pick_target();
      @(posedge clk);
      m_step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
